// File: rtl/line_xfer.sv
// Line transfer engine: moves one 256-bit line to or from a 32-bit backing bus
// as eight acknowledged beats and returns the assembled line on completion.
module line_xfer #(
    parameter int WORDS     = 8,
    parameter int LINE_BITS = 32 * WORDS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_line,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [LINE_BITS-1:0] resp_line,
    output logic [31:0]          mem_addr,
    output logic                 mem_re,
    output logic                 mem_we,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_beat;
    logic [26:0]            r_base;
    logic                   r_write;
    logic [LINE_BITS-1:0]   r_line;

    logic [2:0]             w_beat_next;
    logic                   w_last;
    logic [7:0]             w_cur_lo;
    logic [7:0]             w_next_lo;
    logic [LINE_BITS-1:0]   w_line_merged;
    logic                   w_unused_addr;

    assign req_ready     = (r_state == S_IDLE);
    assign w_beat_next   = r_beat + 3'd1;
    assign w_last        = (r_beat == 3'(WORDS - 1));
    assign w_cur_lo      = {r_beat, 5'b0};
    assign w_next_lo     = {w_beat_next, 5'b0};
    assign w_unused_addr = ^req_addr[4:0];

    // Line register with the current beat's read data folded in, so the final
    // beat's word lands in resp_line on the same edge that enters DONE.
    always_comb begin
        w_line_merged = r_line;
        if (!r_write) begin
            w_line_merged[w_cur_lo +: 32] = mem_rdata;
        end
    end

    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would leak new values mid-block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_beat     <= '0;
            r_base     <= '0;
            r_write    <= 1'b0;
            r_line     <= '0;
            resp_valid <= 1'b0;
            resp_line  <= '0;
            mem_addr   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_base    <= req_addr[31:5];
                        r_write   <= req_write;
                        r_line    <= req_write ? req_line : '0;
                        r_beat    <= '0;
                        mem_addr  <= {req_addr[31:5], 5'b0};
                        mem_re    <= ~req_write;
                        mem_we    <= req_write;
                        mem_wdata <= req_write ? req_line[31:0] : 32'd0;
                        r_state   <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (mem_ack) begin
                        r_line <= w_line_merged;
                        if (w_last) begin
                            mem_re     <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= '0;
                            mem_wdata  <= '0;
                            resp_valid <= 1'b1;
                            resp_line  <= w_line_merged;
                            r_state    <= S_DONE;
                        end else begin
                            // Beat index occupies address bits [4:2]; the base never carries.
                            r_beat    <= w_beat_next;
                            mem_addr  <= {r_base, w_beat_next, 2'b00};
                            mem_wdata <= r_write ? r_line[w_next_lo +: 32] : 32'd0;
                        end
                    end
                end
                S_DONE: begin
                    resp_valid <= 1'b0;
                    r_beat     <= '0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_xfer.sv
// Scoreboard bench for line_xfer: stimulus queues expected beats and responses,
// a responder plays the backing memory, and a monitor checks what the DUT shows.
module tb_line_xfer;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [255:0] req_line;
    logic         req_ready;
    logic         resp_valid;
    logic [255:0] resp_line;
    logic [31:0]  mem_addr;
    logic         mem_re;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_ack;

    line_xfer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_line   (req_line),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_line  (resp_line),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        int          ack_cyc;
    } beat_t;

    typedef struct {
        logic [255:0] line;
        int           cyc;
    } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          resp_seen = 0;
    int          wait_cfg [8];
    logic [31:0] rdata_cfg [8];
    bit          spurious_ack = 1'b0;
    int          r_idx = 0;
    int          wctr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Backing memory model: acks each beat after wait_cfg[beat] idle cycles and
    // drives junk on rdata whenever it is not acknowledging.
    always @(negedge clk) begin
        if (reset) begin
            r_idx = 0;
            wctr = 0;
            mem_ack = spurious_ack;
            mem_rdata = 32'hBAD0_0000;
        end else if (mem_re || mem_we) begin
            if (wctr == wait_cfg[r_idx]) begin
                mem_ack = 1'b1;
                mem_rdata = rdata_cfg[r_idx];
                r_idx = (r_idx + 1) % 8;
                wctr = 0;
            end else begin
                mem_ack = 1'b0;
                mem_rdata = 32'hDEAD_0000 | 32'(wctr);
                wctr++;
            end
        end else begin
            mem_ack = spurious_ack;
            mem_rdata = 32'hBAD0_0000;
        end
    end

    always @(negedge clk) begin
        #1;
        if (!reset) begin
            if (mem_re && mem_we) fail("both_strobes");
            if (mem_re || mem_we) begin
                if (beat_q.size() == 0) begin
                    fail("unexpected_strobe");
                end else begin
                    check("beat_addr", mem_addr, beat_q[0].addr);
                    check("beat_dir", {mem_we, mem_re}, beat_q[0].we ? 2'b10 : 2'b01);
                    if (beat_q[0].we) check("beat_wdata", mem_wdata, beat_q[0].wdata);
                    if (mem_ack) begin
                        check("beat_ack_cycle", cyc, beat_q[0].ack_cyc);
                        void'(beat_q.pop_front());
                    end
                end
            end
            if (resp_valid) begin
                resp_seen++;
                if (resp_q.size() == 0) begin
                    fail("unexpected_resp");
                end else begin
                    check("resp_line", resp_line, resp_q[0].line);
                    check("resp_cycle", cyc, resp_q[0].cyc);
                    void'(resp_q.pop_front());
                end
            end
        end
    end

    task automatic push_expect(input bit wr, input logic [31:0] addr, input logic [255:0] wline, input int acc);
        beat_t        e;
        resp_t        r;
        logic [31:0]  base;
        int           cum;
        base = {addr[31:5], 5'b0};
        cum = 0;
        r.line = '0;
        for (int k = 0; k < 8; k++) begin
            cum += wait_cfg[k];
            e.addr = base + 32'(4 * k);
            e.we = wr;
            e.wdata = wline[32*k +: 32];
            e.ack_cyc = acc + 1 + k + cum;
            beat_q.push_back(e);
            r.line[32*k +: 32] = wr ? wline[32*k +: 32] : rdata_cfg[k];
        end
        r.cyc = acc + 9 + cum;
        resp_q.push_back(r);
    endtask

    task automatic start_req(input bit wr, input logic [31:0] addr, input logic [255:0] wline, output int acc);
        @(negedge clk);
        check("req_ready_before_issue", req_ready, 1'b1);
        acc = cyc;
        push_expect(wr, addr, wline, acc);
        req_valid = 1'b1;
        req_write = wr;
        req_addr = addr;
        req_line = wline;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target);
        for (int i = 0; i < 300; i++) begin
            if (resp_seen >= target) break;
            @(negedge clk);
        end
        check("resp_count", resp_seen, target);
        if (resp_seen < target) begin
            beat_q.delete();
            resp_q.delete();
        end
    endtask

    task automatic set_mem(input logic [31:0] rbase);
        for (int k = 0; k < 8; k++) begin
            wait_cfg[k] = 0;
            rdata_cfg[k] = rbase + 32'(k);
        end
    endtask

    initial begin
        int           acc;
        int           acc2;
        int           seen;
        logic [255:0] wline;
        logic [255:0] wline2;

        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_line = '0;
        set_mem(32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_line", resp_line, '0);
        check("rst_strobes", {mem_re, mem_we}, 2'b00);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Zero-wait read from 0x104 (base 0x100).
        set_mem(32'hA000_0000);
        start_req(1'b0, 32'h0000_0104, '0, acc);
        wait_resp(1);

        // Write to base 0x2E0, word i = 0x11111111*i.
        for (int k = 0; k < 8; k++) wline[32*k +: 32] = 32'h1111_1111 * 32'(k);
        set_mem(32'h0);
        start_req(1'b1, 32'h0000_02E0, wline, acc);
        wait_resp(2);
        repeat (3) @(negedge clk);
        check("resp_line_held", resp_line, wline);

        // Read with 3 wait cycles on beat 2 and 1 on beat 7.
        set_mem(32'hB000_0000);
        wait_cfg[2] = 3;
        wait_cfg[7] = 1;
        start_req(1'b0, 32'h0000_3A40, '0, acc);
        wait_resp(3);
        check("waited_resp_cycle", resp_seen, 3);
        set_mem(32'h0);

        // Spurious acks while idle.
        spurious_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            check("idle_ack_ready", req_ready, 1'b1);
            check("idle_ack_strobes", {mem_re, mem_we}, 2'b00);
        end
        spurious_ack = 1'b0;

        // Conflicting request while busy must be ignored.
        set_mem(32'hC000_0000);
        start_req(1'b0, 32'h0000_0400, '0, acc);
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr = 32'h0000_5000;
            req_line = {8{32'h5555_5555}};
            #2;
            check("busy_ready_low", req_ready, 1'b0);
            @(negedge clk);
        end
        req_valid = 1'b0;
        wait_resp(4);

        // Asynchronous reset during beat 4 of a read.
        set_mem(32'hE000_0000);
        start_req(1'b0, 32'h0000_0700, '0, acc);
        do begin
            @(posedge clk);
            #2;
        end while (cyc < acc + 5);
        check("pre_rst_beat4_addr", mem_addr, 32'h0000_0710);
        seen = resp_seen;
        reset = 1'b1;
        #1;
        beat_q.delete();
        resp_q.delete();
        check("mid_rst_ready", req_ready, 1'b1);
        check("mid_rst_strobes", {mem_re, mem_we}, 2'b00);
        check("mid_rst_addr", mem_addr, 32'h0);
        check("mid_rst_resp", {resp_valid, resp_line}, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("no_resp_after_rst", resp_seen, seen);

        // Top line of the address space: no wrap.
        set_mem(32'hD000_0000);
        start_req(1'b0, 32'hFFFF_FFE0, '0, acc);
        wait_resp(seen + 1);

        // Back-to-back read then write with req_valid held high.
        set_mem(32'h7000_0000);
        for (int k = 0; k < 8; k++) wline2[32*k +: 32] = 32'h0F0F_0000 + 32'(k);
        @(negedge clk);
        acc = cyc;
        acc2 = acc + 10;
        push_expect(1'b0, 32'h0000_0800, '0, acc);
        push_expect(1'b1, 32'h0000_09C0, wline2, acc2);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 32'h0000_0800;
        req_line = '0;
        @(negedge clk);
        req_write = 1'b1;
        req_addr = 32'h0000_09C0;
        req_line = wline2;
        while (cyc < acc2 + 1) begin
            @(negedge clk);
            #2;
            if (cyc == acc + 9) check("b2b_ready_in_done", req_ready, 1'b0);
            if (cyc == acc2) check("b2b_ready_after_done", req_ready, 1'b1);
        end
        req_valid = 1'b0;
        wait_resp(seen + 3);

        repeat (3) @(negedge clk);
        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/line_xfer.md
# line_xfer

Line transfer engine between the 256-bit line-granular data memory and a 32-bit word-wide backing memory bus. It accepts one line read (refill) or line write (writeback) request from the data-memory side. It then serialises the line into eight sequential 32-bit beats on the backing bus, with per-beat acknowledge, and returns the assembled line on completion. It feeds refill lines into, and drains dirty lines out of, the data memory's 256-bit line port.

## Interface
Parameters:
- WORDS, 8, 32-bit words per line; fixed at 8 (counter is 3 bits, line is 256 bits)
- LINE_BITS, 256, line width = 32*WORDS

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  line request present
- req_write  in  1  1 = write line to backing memory, 0 = read line
- req_addr  in  32  line address; bits [4:0] ignored, forced to 0 internally
- req_line  in  256  write line, word i at [32i+31:32i]; sampled only at acceptance
- req_ready  out  1  engine idle, request accepted this cycle if req_valid=1
- resp_valid  out  1  one-cycle pulse: transfer complete
- resp_line  out  256  read: assembled line; write: the line written; held until next acceptance
- mem_addr  out  32  beat address
- mem_re  out  1  beat read strobe
- mem_we  out  1  beat write strobe
- mem_wdata  out  32  beat write data
- mem_rdata  in  32  beat read data, valid when mem_ack=1
- mem_ack  in  1  beat complete; meaningful only while mem_re or mem_we is 1

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch {req_addr[31:5],5'b0}, req_write and req_line into internal regs; clear beat counter; go to XFER.
- XFER:
  - Strobe mem_re (read) or mem_we (write); mem_addr = base + 4*beat; mem_wdata = latched line word[beat].
  - Strobe and address are held stable until mem_ack=1.
  - On mem_ack with read: write mem_rdata into line reg word[beat].
  - On mem_ack and beat<7: beat+1, stay in XFER.
  - On mem_ack and beat==7: go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_line = line reg; go to IDLE.
- Never both mem_re and mem_we high. Both are 0 outside XFER.
- mem_ack outside XFER is ignored; it causes no state or data change.
- req_valid outside IDLE is ignored. There is no queue; the requester holds the request until req_ready.
- Addressing: base[31:5] is constant for the whole transfer, so beat addresses never carry out of the line (base+0x00..base+0x1C). A request at line 0xFFFFFFE0 is legal and does not wrap.
- resp_line for a write equals the latched req_line. For a read, it equals the eight acknowledged rdata words in beat order.

## Timing
- Reset (async assert, any state):
  - state=IDLE, beat=0, req_ready=1, resp_valid=0, resp_line=0.
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - An in-flight transfer is abandoned with no resp_valid. Partially filled line data is discarded.
- Outputs are registered (mem_*, resp_*) or decoded from state only (req_ready); there is no combinational path from inputs to outputs.
- Acceptance edge E0 (req_valid & req_ready). First strobe is visible in cycle E0+1.
- A beat whose ack arrives in the same cycle as its strobe advances with no bubble. The next address or strobe is visible in the following cycle.
- Zero-wait transfer: strobes in cycles 1-8, resp_valid in cycle 9, req_ready=1 again in cycle 10. Each wait cycle on any beat adds 1.
- A new request may be accepted in the first IDLE cycle after DONE.

## Test plan
- Zero-wait read, req_addr=0x0000_0104 (base 0x100): ack tied high, rdata = 0xA000_0000+beat.
  - mem_addr steps 0x100..0x11C in cycles 1-8.
  - resp_valid only in cycle 9.
  - resp_line word i = 0xA000_000i.
- Write, base 0x2E0, req_line word i = 0x1111_1111*i, ack high.
  - mem_we in cycles 1-8, mem_wdata = 0x1111_1111*beat.
  - mem_re stays 0; resp_line equals req_line.
- Waited read: ack delayed 3 cycles on beat 2 and 1 cycle on beat 7.
  - mem_addr 0x...08 is held for 4 cycles.
  - resp_valid in cycle 13.
  - Data is captured only on ack cycles.
- Spurious ack and busy requests:
  - mem_ack pulsed in IDLE: no strobe, no state change.
  - req_valid with a different address during XFER: ignored; the original transfer completes unchanged.
- Reset mid-transfer: assert reset asynchronously during beat 4 of a read.
  - All outputs go to 0 immediately, with req_ready=1.
  - No resp_valid.
  - The next read of base 0xFFFF_FFE0 completes with addresses 0xFFFF_FFE0..0xFFFF_FFFC and no wrap.
- Back-to-back: a read then a write, req_valid held high throughout.
  - The second request is accepted in the cycle after resp_valid.
  - The second request's strobes start the following cycle.
